hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core. Decodes the IF/ID, ID/EX and EX/MEM instruction registers, the EX-stage redirect, and the data-memory ready handshake. From these it generates pipeline-register write enables, bubbles and flushes that sequence the forwarding datapath. It covers the hazards forwarding cannot resolve: load-use, branch/jump redirect and multi-cycle data-memory access. It also keeps a memory-timeout watchdog and saturating performance counters.

---
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl : stall/flush/freeze sequencing for the 5-stage RV32I pipeline,
//               with data-memory watchdog and saturating performance counters.
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [31:0]      if_id_ir_i,
  input  logic [31:0]      id_ex_ir_i,
  input  logic [31:0]      ex_mem_ir_i,
  input  logic             ex_redirect_i,
  input  logic             dmem_ready_i,
  output logic             pc_we_o,
  output logic             if_id_we_o,
  output logic             id_ex_bubble_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             freeze_o,
  output logic             mem_timeout_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_events_o
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;

  localparam int              WCNT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(TIMEOUT);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [6:0] w_if_op, w_ex_op, w_mem_op;
  logic [4:0] w_if_rs1, w_if_rs2, w_ex_rd;
  logic       w_uses_rs1, w_uses_rs2, w_load_use, w_mem_access, w_mem_hold;
  logic       unused_ir_bits;

  assign w_if_op  = if_id_ir_i[6:0];
  assign w_ex_op  = id_ex_ir_i[6:0];
  assign w_mem_op = ex_mem_ir_i[6:0];
  assign w_if_rs1 = if_id_ir_i[19:15];
  assign w_if_rs2 = if_id_ir_i[24:20];
  assign w_ex_rd  = id_ex_ir_i[11:7];

  assign w_uses_rs1 = (w_if_op != OP_LUI) && (w_if_op != OP_AUIPC) &&
                      (w_if_op != OP_JAL) && (w_if_op != 7'b0000000);
  assign w_uses_rs2 = (w_if_op == OP_RTYPE) || (w_if_op == OP_STORE) ||
                      (w_if_op == OP_BRANCH);

  assign w_load_use = (w_ex_op == OP_LOAD) && (w_ex_rd != 5'd0) &&
                      ((w_uses_rs1 && (w_if_rs1 == w_ex_rd)) ||
                       (w_uses_rs2 && (w_if_rs2 == w_ex_rd)));

  assign w_mem_access = (w_mem_op == OP_LOAD) || (w_mem_op == OP_STORE);

  // In MEM_WAIT the access is already known to be outstanding, so only ready matters.
  assign w_mem_hold = ((state_q == ST_MEM_WAIT) || w_mem_access) && !dmem_ready_i;

  assign unused_ir_bits = ^{if_id_ir_i[31:25], if_id_ir_i[14:7],
                            id_ex_ir_i[31:12], ex_mem_ir_i[31:7]};

  always_comb begin
    pc_we_o        = 1'b1;
    if_id_we_o     = 1'b1;
    id_ex_bubble_o = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    freeze_o       = 1'b0;
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;

    if (!rst_n_i) begin
      pc_we_o       = 1'b0;
      if_id_we_o    = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if (w_mem_hold) begin
            freeze_o   = 1'b1;
            pc_we_o    = 1'b0;
            if_id_we_o = 1'b0;
            if (state_q == ST_RUN) begin
              state_d    = ST_MEM_WAIT;
              wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_MAX) begin
              state_d       = ST_TIMEOUT;
              mem_timeout_d = 1'b1;
            end else begin
              wait_cnt_d = wait_cnt_q + 1'b1;
            end
          end else begin
            state_d = ST_RUN;
            if (ex_redirect_i) begin
              if_id_flush_o = 1'b1;
              id_ex_flush_o = 1'b1;
            end else if (w_load_use) begin
              pc_we_o        = 1'b0;
              if_id_we_o     = 1'b0;
              id_ex_bubble_o = 1'b1;
            end
          end
        end
        ST_TIMEOUT: begin
          freeze_o      = 1'b1;
          pc_we_o       = 1'b0;
          if_id_we_o    = 1'b0;
          mem_timeout_d = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((freeze_o || id_ex_bubble_o) && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (if_id_flush_o && rst_n_i && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign mem_timeout_o  = mem_timeout_q;
  assign state_o        = state_q;
  assign stall_cycles_o = stall_cnt_q;
  assign flush_events_o = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl : directed and randomized checks of hazard_ctrl against a
//                  behavioural model of the hazard rules.
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] LW5     = 32'h0000A283;
  localparam logic [31:0] LW0     = 32'h0000A003;
  localparam logic [31:0] ADD_X5  = 32'h00228333;
  localparam logic [31:0] ADD_X0  = 32'h00200333;
  localparam logic [31:0] LUI5    = 32'h000012B7;
  localparam logic [31:0] JAL5    = 32'h000002EF;
  localparam logic [31:0] SW      = 32'h0020A023;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   if_id_ir, id_ex_ir, ex_mem_ir;
  logic          ex_redirect, dmem_ready;
  logic          pc_we, if_id_we, id_ex_bubble, if_id_flush, id_ex_flush, freeze, mem_timeout;
  logic [1:0]    state;
  logic [CW-1:0] stall_cycles, flush_events;

  int n_chk  = 0;
  int n_pass = 0;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .if_id_ir_i     (if_id_ir),
    .id_ex_ir_i     (id_ex_ir),
    .ex_mem_ir_i    (ex_mem_ir),
    .ex_redirect_i  (ex_redirect),
    .dmem_ready_i   (dmem_ready),
    .pc_we_o        (pc_we),
    .if_id_we_o     (if_id_we),
    .id_ex_bubble_o (id_ex_bubble),
    .if_id_flush_o  (if_id_flush),
    .id_ex_flush_o  (id_ex_flush),
    .freeze_o       (freeze),
    .mem_timeout_o  (mem_timeout),
    .state_o        (state),
    .stall_cycles_o (stall_cycles),
    .flush_events_o (flush_events)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_load(input logic [31:0] ir);
    return ir[6:0] == 7'b0000011;
  endfunction
  function automatic bit is_mem(input logic [31:0] ir);
    return is_load(ir) || ir[6:0] == 7'b0100011;
  endfunction
  function automatic bit reads_rs1(input logic [31:0] ir);
    return !(ir[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b0000000});
  endfunction
  function automatic bit reads_rs2(input logic [31:0] ir);
    return ir[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction
  function automatic bit hazard(input logic [31:0] ex, input logic [31:0] id);
    int rd;
    rd = int'(ex[11:7]);
    if (!is_load(ex) || rd == 0) return 0;
    return (reads_rs1(id) && int'(id[19:15]) == rd) || (reads_rs2(id) && int'(id[24:20]) == rd);
  endfunction

  // m_episode: frozen cycles so far in the current memory stall (RUN cycle included)
  int m_state = 0, m_episode = 0, m_flag = 0, m_stall = 0, m_flush = 0;
  int n_state = 0, n_episode = 0, n_flag = 0, n_stall = 0, n_flush = 0;

  always @(negedge clk) begin
    bit e_pc, e_ifw, e_bub, e_iff, e_idf, e_frz;
    e_pc = 1; e_ifw = 1; e_bub = 0; e_iff = 0; e_idf = 0; e_frz = 0;
    n_state = m_state; n_episode = m_episode; n_flag = m_flag;
    n_stall = m_stall; n_flush = m_flush;
    if (!rst_n) begin
      e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1;
      n_state = 0; n_episode = 0; n_flag = 0; n_stall = 0; n_flush = 0;
    end else begin
      if (m_state == 2) begin
        e_frz = 1; e_pc = 0; e_ifw = 0;
      end else if (!dmem_ready && (m_state == 1 || is_mem(ex_mem_ir))) begin
        e_frz = 1; e_pc = 0; e_ifw = 0;
        n_episode = (m_state == 0) ? 1 : m_episode + 1;
        if (n_episode == TO + 2) begin n_state = 2; n_flag = 1; end
        else n_state = 1;
      end else begin
        n_state = 0;
        if (ex_redirect) begin e_iff = 1; e_idf = 1; end
        else if (hazard(id_ex_ir, if_id_ir)) begin e_bub = 1; e_pc = 0; e_ifw = 0; end
      end
      if (e_frz || e_bub) n_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (e_iff)          n_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
    end
    check("pc_we",        {31'd0, pc_we},        {31'd0, e_pc});
    check("if_id_we",     {31'd0, if_id_we},     {31'd0, e_ifw});
    check("id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, e_bub});
    check("if_id_flush",  {31'd0, if_id_flush},  {31'd0, e_iff});
    check("id_ex_flush",  {31'd0, id_ex_flush},  {31'd0, e_idf});
    check("freeze",       {31'd0, freeze},       {31'd0, e_frz});
    check("mem_timeout",  {31'd0, mem_timeout},  32'(m_flag));
    check("state",        {30'd0, state},        32'(m_state));
    check("stall_cycles", 32'(stall_cycles),     32'(m_stall));
    check("flush_events", 32'(flush_events),     32'(m_flush));
  end

  always @(posedge clk) begin
    m_state   <= n_state;
    m_episode <= n_episode;
    m_flag    <= n_flag;
    m_stall   <= n_stall;
    m_flush   <= n_flush;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_id_ir = NOP; id_ex_ir = NOP; ex_mem_ir = NOP;
    ex_redirect = 1'b0; dmem_ready = 1'b1;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [6:0]  ops [10];
    logic [31:0] r;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100011, 7'b1100111, 7'b0000000};
    r = $urandom;
    r[6:0]   = ops[$urandom_range(0, 9)];
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  int s0, f0, hang;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_stall", 32'(stall_cycles), 32'd0);
    check("reset_flush", 32'(flush_events), 32'd0);

    // load-use: one stall cycle, then the bubble in ID/EX clears it
    tick();
    id_ex_ir = LW5; if_id_ir = ADD_X5;
    #1;
    check("lu_pc_we", {31'd0, pc_we}, 32'd0);
    check("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
    tick();
    id_ex_ir = NOP;
    #1;
    check("lu_stall_cnt", 32'(stall_cycles), 32'd1);
    check("lu_resume", {31'd0, pc_we}, 32'd1);
    tick();
    id_ex_ir = LW0; if_id_ir = ADD_X0;
    #1;
    check("lu_x0_pc_we", {31'd0, pc_we}, 32'd1);
    tick();
    id_ex_ir = LW5; if_id_ir = LUI5;
    #1;
    check("lu_lui_bubble", {31'd0, id_ex_bubble}, 32'd0);
    tick();
    if_id_ir = JAL5;
    #1;
    check("lu_jal_pc_we", {31'd0, pc_we}, 32'd1);
    tick();

    // memory wait, three not-ready cycles
    idle_inputs();
    s0 = int'(stall_cycles);
    ex_mem_ir = SW; dmem_ready = 1'b0;
    #1;
    check("mw_freeze0", {31'd0, freeze}, 32'd1);
    tick(); #1;
    check("mw_state", {30'd0, state}, 32'd1);
    tick(); #1;
    check("mw_freeze2", {31'd0, freeze}, 32'd1);
    tick();
    dmem_ready = 1'b1;
    #1;
    check("mw_release", {31'd0, freeze}, 32'd0);
    tick();
    ex_mem_ir = NOP;
    #1;
    check("mw_stall_cnt", 32'(int'(stall_cycles) - s0), 32'd3);
    check("mw_back_run", {30'd0, state}, 32'd0);

    // redirect held across a two-cycle wait
    f0 = int'(flush_events);
    ex_mem_ir = SW; dmem_ready = 1'b0; ex_redirect = 1'b1;
    #1;
    check("rw_noflush0", {31'd0, if_id_flush}, 32'd0);
    tick(); #1;
    check("rw_noflush1", {31'd0, id_ex_flush}, 32'd0);
    tick();
    dmem_ready = 1'b1;
    #1;
    check("rw_flush_if", {31'd0, if_id_flush}, 32'd1);
    check("rw_flush_id", {31'd0, id_ex_flush}, 32'd1);
    tick();
    idle_inputs();
    #1;
    check("rw_flush_cnt", 32'(int'(flush_events) - f0), 32'd1);

    // redirect wins over load-use
    id_ex_ir = LW5; if_id_ir = ADD_X5; ex_redirect = 1'b1;
    #1;
    check("rl_flush", {31'd0, if_id_flush}, 32'd1);
    check("rl_bubble", {31'd0, id_ex_bubble}, 32'd0);
    check("rl_pc_we", {31'd0, pc_we}, 32'd1);
    tick();
    idle_inputs();

    // watchdog: six frozen cycles then TIMEOUT
    ex_mem_ir = SW; dmem_ready = 1'b0;
    #1;
    check("to_freeze_run", {31'd0, freeze}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      check("to_wait_state", {30'd0, state}, 32'd1);
    end
    tick(); #1;
    check("to_state", {30'd0, state}, 32'd2);
    check("to_flag", {31'd0, mem_timeout}, 32'd1);
    dmem_ready = 1'b1;
    tick(); #1;
    check("to_sticky_state", {30'd0, state}, 32'd2);
    check("to_sticky_freeze", {31'd0, freeze}, 32'd1);
    for (int i = 0; i < 70; i++) tick();
    check("to_stall_sat", 32'(stall_cycles), 32'(CMAX));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("to_reset_state", {30'd0, state}, 32'd0);
    check("to_reset_flag", {31'd0, mem_timeout}, 32'd0);

    // randomized phase
    hang = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if_id_ir    = rand_ir();
      id_ex_ir    = rand_ir();
      ex_mem_ir   = rand_ir();
      ex_redirect = ($urandom_range(0, 4) == 0);
      dmem_ready  = ($urandom_range(0, 9) < 6);
      if (hang > 0) begin dmem_ready = 1'b0; hang--; end
      else if ($urandom_range(0, 99) == 0) hang = 8;
      rst_n = 1'b1;
      if (m_state == 2 && $urandom_range(0, 3) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
    end
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
